// File: rtl/mem_port_arbiter.sv
// Two-master arbiter sharing one single-port memory between instruction fetch and load/store.
// Define ARB_WATCHDOG_EN to add a per-transaction timeout with error reporting.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_valid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_ack,
   input  logic [31:0] m_rdata,
   output logic        err,
   output logic        err_flag
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   state_t        state;
   logic [SW-1:0] starve_cnt;
   logic [31:0]   i_hold;
   logic [31:0]   d_hold;
   logic          starve_force;
   logic          grant_i;
   logic          grant_d;
   logic          busy;
   logic          timeout;
   logic          done;
   logic [31:0]   resp_data;

   // Fetch only beats a pending data request once data has won STARVE_LIMIT times in a row.
   assign starve_force = (STARVE_LIMIT != 0) && (starve_cnt == SW'(STARVE_LIMIT));
   assign grant_i      = i_req && (!d_req || starve_force);
   assign grant_d      = d_req && !grant_i;

   assign busy      = (state != IDLE);
   assign done      = busy && (m_ack || timeout);
   assign resp_data = timeout ? TIMEOUT_DATA : m_rdata;

   assign i_valid = (state == BUSY_I) && done;
   assign d_valid = (state == BUSY_D) && done;
   assign i_rdata = i_valid ? resp_data : i_hold;
   assign d_rdata = d_valid ? resp_data : d_hold;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_wstrb    <= '0;
         starve_cnt <= '0;
         i_hold     <= '0;
         d_hold     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_i) begin
                  state      <= BUSY_I;
                  m_req      <= 1'b1;
                  m_we       <= 1'b0;
                  m_addr     <= i_addr;
                  m_wdata    <= '0;
                  m_wstrb    <= 4'b0000;
                  starve_cnt <= '0;
               end else if (grant_d) begin
                  state   <= BUSY_D;
                  m_req   <= 1'b1;
                  m_we    <= d_we;
                  m_addr  <= d_addr;
                  m_wdata <= d_wdata;
                  m_wstrb <= d_we ? d_wstrb : 4'b0000;
                  if (!i_req) begin
                     starve_cnt <= '0;
                  end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                     starve_cnt <= starve_cnt + 1'b1;
                  end
               end else begin
                  starve_cnt <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (done) begin
                  state <= IDLE;
                  m_req <= 1'b0;
                  if (state == BUSY_I) begin
                     i_hold <= resp_data;
                  end else begin
                     d_hold <= resp_data;
                  end
               end
            end
            default: begin
               state <= IDLE;
               m_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef ARB_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   logic [WW-1:0] wd_cnt;
   logic          err_flag_q;

   // Counter sits at zero in IDLE, so the TIMEOUT_CYCLES-th busy cycle is the one that expires.
   assign timeout  = busy && !m_ack && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
   assign err      = timeout;
   assign err_flag = err_flag_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt     <= '0;
         err_flag_q <= 1'b0;
      end else begin
         if (!busy || done) begin
            wd_cnt <= '0;
         end else begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (timeout) begin
            err_flag_q <= 1'b1;
         end
      end
   end
`else
   // Keeps the watchdog parameter referenced when the feature is compiled out.
   localparam int unused_timeout = TIMEOUT_CYCLES;

   assign timeout  = 1'b0;
   assign err      = 1'b0;
   assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grants,
// completions and read data against a behavioural memory owned by the bench.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int STARVE = 4;
   localparam int TO     = 8;
`ifdef ARB_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_valid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_ack;
   logic [31:0] m_rdata;
   logic        err;
   logic        err_flag;

   mem_port_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_valid(d_valid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ack(m_ack), .m_rdata(m_rdata), .err(err), .err_flag(err_flag)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] mem  [128];
   logic [31:0] refm [128];
   bit          busy, finished, ownerI, memMute, holdMode, errFlagExp, iDone, dDone;
   int          busyCycles, ackDelay, forcedDelay, spurPct, genPct, starve;
   int          lastBusyLen, timeoutsSeen, iCount, dCount;
   logic [31:0] lastI, lastD, expAddr;
   int          grantLog[$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
      return r;
   endfunction

   task automatic issueFetch(input logic [31:0] a);
      i_req  = 1'b1;
      i_addr = a;
   endtask

   task automatic issueData(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] s);
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      d_wstrb = s;
   endtask

   // Requesters drop or renew a request only in the cycle after its valid.
   task automatic applyStimulus();
      if (iDone) begin
         i_req = 1'b0;
         iDone = 1'b0;
         if (holdMode) issueFetch(32'($urandom_range(127)) << 2);
      end
      if (dDone) begin
         d_req = 1'b0;
         dDone = 1'b0;
         if (holdMode) issueData(1'($urandom_range(1)), 32'($urandom_range(127)) << 2,
                                 $urandom, 4'($urandom_range(15)));
      end
      if (!i_req && $urandom_range(99) < genPct) issueFetch(32'($urandom_range(127)) << 2);
      if (!d_req && $urandom_range(99) < genPct)
         issueData(1'($urandom_range(1)), 32'($urandom_range(127)) << 2, $urandom,
                   4'($urandom_range(15)));
   endtask

   task automatic step();
      bit          wantI, wantD, ack, tmo, done;
      logic [31:0] rd, expData;
      @(posedge clk);
      #1;
      if (!busy) begin
         wantI = i_req && (!d_req || (STARVE != 0 && starve == STARVE));
         wantD = d_req && !wantI;
         checkOutput("m_req_grant", 32'(m_req), 32'(wantI || wantD));
         if (wantI) begin
            ownerI  = 1'b1;
            expAddr = i_addr;
            starve  = 0;
            checkOutput("fetch_we", 32'(m_we), 32'd0);
            checkOutput("fetch_wstrb", 32'(m_wstrb), 32'd0);
            grantLog.push_back(1);
         end else if (wantD) begin
            ownerI  = 1'b0;
            expAddr = d_addr;
            starve  = i_req ? ((starve < STARVE) ? starve + 1 : STARVE) : 0;
            checkOutput("data_we", 32'(m_we), 32'(d_we));
            checkOutput("data_wstrb", 32'(m_wstrb), d_we ? 32'(d_wstrb) : 32'd0);
            if (d_we) checkOutput("data_wdata", m_wdata, d_wdata);
            grantLog.push_back(0);
         end else begin
            starve = 0;
         end
         busy       = wantI || wantD;
         busyCycles = 0;
         ackDelay   = (forcedDelay >= 0) ? forcedDelay : int'($urandom_range(3));
      end else if (finished) begin
         busy     = 1'b0;
         finished = 1'b0;
         checkOutput("m_req_drop", 32'(m_req), 32'd0);
      end else begin
         checkOutput("m_req_hold", 32'(m_req), 32'd1);
      end
      if (busy) checkOutput("m_addr", m_addr, expAddr);
      applyStimulus();

      ack = 1'b0;
      rd  = $urandom;
      if (busy) begin
         busyCycles++;
         ack = !memMute && (busyCycles > ackDelay);
         if (ack && !m_we) rd = mem[m_addr[8:2]];
         if (ack && m_we) mem[m_addr[8:2]] = mergeBytes(mem[m_addr[8:2]], m_wdata, m_wstrb);
      end else begin
         ack = ($urandom_range(99) < spurPct);
      end
      m_ack   = ack;
      m_rdata = rd;
      #1;

      tmo  = WD_ON && busy && !ack && (busyCycles == TO);
      done = busy && !finished && (ack || tmo);
      checkOutput("i_valid", 32'(i_valid), 32'(done && ownerI));
      checkOutput("d_valid", 32'(d_valid), 32'(done && !ownerI));
      checkOutput("err", 32'(err), 32'(tmo));
      checkOutput("err_flag", 32'(err_flag), 32'(errFlagExp));
      if (done) begin
         if (tmo)         expData = 32'hDEADBEEF;
         else if (ownerI) expData = refm[i_addr[8:2]];
         else if (d_we)   expData = rd;
         else             expData = refm[d_addr[8:2]];
         if (ownerI) begin
            checkOutput("i_rdata", i_rdata, expData);
            lastI = expData;
            iDone = 1'b1;
            iCount++;
         end else begin
            checkOutput("d_rdata", d_rdata, expData);
            lastD = expData;
            dDone = 1'b1;
            dCount++;
            if (d_we && !tmo) refm[d_addr[8:2]] = mergeBytes(refm[d_addr[8:2]], d_wdata, d_wstrb);
         end
         lastBusyLen = busyCycles;
         finished    = 1'b1;
      end
      if (!(done && ownerI))  checkOutput("i_hold", i_rdata, lastI);
      if (!(done && !ownerI)) checkOutput("d_hold", d_rdata, lastD);
      if (tmo) begin
         errFlagExp = 1'b1;
         timeoutsSeen++;
      end
   endtask

   task automatic runUntilQuiet(input int maxCycles);
      int n;
      for (n = 0; n < maxCycles; n++) begin
         step();
         if (!busy && !i_req && !d_req) break;
      end
      if (n >= maxCycles) checkOutput("quiet_bound", 32'd0, 32'd1);
   endtask

   task automatic resetChecks(input string tag);
      checkOutput({tag, "_m_req"}, 32'(m_req), 32'd0);
      checkOutput({tag, "_m_we"}, 32'(m_we), 32'd0);
      checkOutput({tag, "_m_addr"}, m_addr, 32'd0);
      checkOutput({tag, "_m_wdata"}, m_wdata, 32'd0);
      checkOutput({tag, "_m_wstrb"}, 32'(m_wstrb), 32'd0);
      checkOutput({tag, "_i_valid"}, 32'(i_valid), 32'd0);
      checkOutput({tag, "_d_valid"}, 32'(d_valid), 32'd0);
      checkOutput({tag, "_err"}, 32'(err), 32'd0);
      checkOutput({tag, "_err_flag"}, 32'(err_flag), 32'd0);
      checkOutput({tag, "_i_rdata"}, i_rdata, 32'd0);
      checkOutput({tag, "_d_rdata"}, d_rdata, 32'd0);
   endtask

   task automatic doReset();
      #1 reset = 1'b1;
      #1;
      m_ack = 1'b0;
      resetChecks("midrst");
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      busy = 0; finished = 0; starve = 0; lastI = '0; lastD = '0;
      errFlagExp = 0; iDone = 0; dDone = 0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL global_time_limit: simulation did not finish");
      $fatal(1, "[TB] stopped");
   end

   initial begin
      int          pattern[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int          i0, d0;
      logic [31:0] wd;
      reset = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
      d_wdata = '0; d_wstrb = '0; m_ack = 0; m_rdata = '0;
      busy = 0; finished = 0; ownerI = 0; memMute = 0; holdMode = 0; errFlagExp = 0;
      iDone = 0; dDone = 0; busyCycles = 0; ackDelay = 0; forcedDelay = -1; spurPct = 0;
      genPct = 0; starve = 0; lastBusyLen = 0; timeoutsSeen = 0; iCount = 0; dCount = 0;
      lastI = '0; lastD = '0; expAddr = '0;
      for (int i = 0; i < 128; i++) begin
         mem[i]  = $urandom;
         refm[i] = mem[i];
      end
      repeat (2) @(posedge clk);
      #2;
      resetChecks("rst");
      #1 reset = 1'b0;

      $display("[TB] single fetch with two-cycle memory");
      mem[4] = 32'h00A00093;
      refm[4] = 32'h00A00093;
      forcedDelay = 1;
      i0 = iCount; d0 = dCount;
      issueFetch(32'h10);
      runUntilQuiet(20);
      checkOutput("fetch_busy_len", 32'(lastBusyLen), 32'd2);
      checkOutput("fetch_count", 32'(iCount - i0), 32'd1);
      checkOutput("fetch_no_dvalid", 32'(dCount - d0), 32'd0);
      checkOutput("fetch_hold_val", i_rdata, 32'h00A00093);

      $display("[TB] simultaneous fetch and store");
      forcedDelay = 0;
      grantLog.delete();
      i0 = iCount; d0 = dCount;
      issueFetch(32'h20);
      issueData(1'b1, 32'h100, 32'hCAFEBABE, 4'b1111);
      runUntilQuiet(20);
      checkOutput("sim_grants", 32'(grantLog.size()), 32'd2);
      if (grantLog.size() == 2) begin
         checkOutput("sim_first", 32'(grantLog[0]), 32'd0);
         checkOutput("sim_second", 32'(grantLog[1]), 32'd1);
      end
      checkOutput("sim_icount", 32'(iCount - i0), 32'd1);
      checkOutput("sim_dcount", 32'(dCount - d0), 32'd1);
      checkOutput("sim_store_mem", mem[64], 32'hCAFEBABE);

      $display("[TB] starvation guard with both ports saturated");
      grantLog.delete();
      holdMode = 1;
      issueFetch(32'h40);
      issueData(1'b0, 32'h80, 32'd0, 4'd0);
      for (int n = 0; n < 100 && grantLog.size() < 10; n++) step();
      holdMode = 0;
      runUntilQuiet(40);
      checkOutput("starve_len", 32'(grantLog.size() >= 10), 32'd1);
      if (grantLog.size() >= 10)
         for (int k = 0; k < 10; k++) checkOutput($sformatf("starve_order%0d", k),
                                                  32'(grantLog[k]), 32'(pattern[k]));

      $display("[TB] reset during a data transaction");
      forcedDelay = -1;
      memMute = 1;
      d0 = dCount;
      issueData(1'b0, 32'h44, 32'd0, 4'd0);
      repeat (3) step();
      checkOutput("pre_rst_m_req", 32'(m_req), 32'd1);
      doReset();
      memMute = 0;
      checkOutput("rst_no_dvalid", 32'(dCount - d0), 32'd0);
      runUntilQuiet(20);
      checkOutput("reissue_done", 32'(dCount - d0), 32'd1);

      $display("[TB] randomized traffic");
      genPct = 40;
      spurPct = 20;
      i0 = iCount; d0 = dCount;
      repeat (1500) step();
      genPct = 0;
      spurPct = 0;
      runUntilQuiet(60);
      checkOutput("rand_fetches", 32'(iCount > i0), 32'd1);
      checkOutput("rand_datas", 32'(dCount > d0), 32'd1);
      for (int i = 0; i < 128; i++) checkOutput($sformatf("mem%0d", i), mem[i], refm[i]);

`ifdef ARB_WATCHDOG_EN
      $display("[TB] watchdog expiry on a silent memory");
      memMute = 1;
      timeoutsSeen = 0;
      issueData(1'b0, 32'h8, 32'd0, 4'd0);
      runUntilQuiet(40);
      memMute = 0;
      checkOutput("wd_busy_len", 32'(lastBusyLen), 32'(TO));
      checkOutput("wd_timeouts", 32'(timeoutsSeen), 32'd1);
      checkOutput("wd_hold", d_rdata, 32'hDEADBEEF);
      forcedDelay = 0;
      issueFetch(32'hC);
      runUntilQuiet(20);
      checkOutput("wd_flag_sticky", 32'(err_flag), 32'd1);
      checkOutput("wd_fetch_ok", i_rdata, refm[3]);
`endif

      wd = 32'(errors);
      $display("[TB] sequence complete, last error count %0d", wd);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
